// File: rtl/mips_data_bus_bridge.sv
// Bridges the CPU's combinational-read data port onto a waitrequest memory bus,
// stalling the CPU via clk_enable until each access completes or times out.
module mips_data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERROR_READDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error,
    output logic [1:0]  check_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        READ_REQ  = 2'b01,
        WRITE_REQ = 2'b10,
        DONE      = 2'b11
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] tmo_cnt;
    logic        cpu_req;
    logic        in_req;
    logic        timeout_hit;

    assign cpu_req     = cpu_data_read | cpu_data_write;
    assign in_req      = (state == READ_REQ) || (state == WRITE_REQ);
    // Abort at the end of the TIMEOUT_CYCLES-th request cycle; a completing bus wins that cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && ((tmo_cnt + 32'd1) == TIMEOUT_CYCLES);
    assign check_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_data_write) begin
                    next_state = WRITE_REQ;
                end else if (cpu_data_read) begin
                    next_state = READ_REQ;
                end
            end
            READ_REQ, WRITE_REQ: begin
                if (!bus_waitrequest || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_clk_enable = !(((state == IDLE) && cpu_req) || in_req);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_address       <= '0;
            bus_writedata     <= '0;
            bus_byteenable    <= '0;
            bus_read          <= 1'b0;
            bus_write         <= 1'b0;
            cpu_data_readdata <= '0;
            bus_error         <= 1'b0;
            tmo_cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (cpu_req) begin
                        bus_address    <= cpu_data_address & 32'hFFFF_FFFC;
                        bus_writedata  <= cpu_data_writedata;
                        bus_byteenable <= cpu_byteenable;
                        bus_write      <= cpu_data_write;
                        bus_read       <= cpu_data_read & ~cpu_data_write;
                    end
                end
                READ_REQ, WRITE_REQ: begin
                    if (!bus_waitrequest) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (state == READ_REQ) begin
                            cpu_data_readdata <= bus_readdata;
                        end
                    end else if (timeout_hit) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        bus_error <= 1'b1;
                        if (state == READ_REQ) begin
                            cpu_data_readdata <= ERROR_READDATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                DONE: begin
                    tmo_cnt <= '0;
                end
                default: begin
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Scoreboard bench for mips_data_bus_bridge: CPU-side accesses push expected bus
// transactions and read results, which are popped as the bus and DONE state appear.
module tb_mips_data_bus_bridge;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_data_address = '0;
    logic        cpu_data_read = 1'b0;
    logic        cpu_data_write = 1'b0;
    logic [31:0] cpu_data_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clk_enable;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest = 1'b0;
    logic [31:0] bus_readdata = '0;
    logic        bus_error;
    logic [1:0]  check_state;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_rdata = '0;
    bit          model_err = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned pulses = 0;
    logic        prev_strobe = 1'b0;

    mips_data_bus_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .ERROR_READDATA(ERR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_data_address  (cpu_data_address),
        .cpu_data_read     (cpu_data_read),
        .cpu_data_write    (cpu_data_write),
        .cpu_data_writedata(cpu_data_writedata),
        .cpu_byteenable    (cpu_byteenable),
        .cpu_data_readdata (cpu_data_readdata),
        .cpu_clk_enable    (cpu_clk_enable),
        .bus_address       (bus_address),
        .bus_read          (bus_read),
        .bus_write         (bus_write),
        .bus_writedata     (bus_writedata),
        .bus_byteenable    (bus_byteenable),
        .bus_waitrequest   (bus_waitrequest),
        .bus_readdata      (bus_readdata),
        .bus_error         (bus_error),
        .check_state       (check_state)
    );

    always #5 clk = ~clk;

    // Counts bus pulse trains so duplicate transactions are visible.
    always @(negedge clk) begin
        if ((bus_read || bus_write) && !prev_strobe) pulses++;
        prev_strobe = bus_read || bus_write;
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata, input int unsigned waits,
                              input bit tmo, input int unsigned exp_stall,
                              input int unsigned exp_strobe, input string name);
        bus_exp_t    e;
        bus_exp_t    cur;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        int unsigned stall = 0;
        int unsigned strobe_cyc = 0;
        int unsigned reqn = 0;
        bit          have = 1'b0;
        bit          done = 1'b0;
        @(negedge clk);
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_address   = addr;
        cpu_data_writedata = wdata;
        cpu_byteenable     = be;
        bus_readdata       = rdata;
        bus_waitrequest    = 1'b1;
        e.wr   = wr;
        e.addr = {addr[31:2], 2'b00};
        e.data = wdata;
        e.be   = be;
        bus_q.push_back(e);
        if (!wr && rd) model_rdata = tmo ? ERR : rdata;
        rd_q.push_back(model_rdata);
        if (tmo) model_err = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 0) begin
                n_cmp++;
                if (check_state !== 2'b00 || cpu_clk_enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s.idle_stall: state=%b en=%b required state=00 en=0",
                             name, check_state, cpu_clk_enable);
                end
            end
            if (!cpu_clk_enable) stall++;
            if (check_state == 2'b01 || check_state == 2'b10) begin
                bus_waitrequest = (reqn < waits);
                reqn++;
                if (bus_read || bus_write) strobe_cyc++;
                if (!have) begin
                    n_cmp++;
                    if (bus_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s.bus_q: bus request with no expected transaction", name);
                    end else begin
                        cur  = bus_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    n_cmp++;
                    if ({bus_write, bus_read} !== {cur.wr, !cur.wr} || bus_address !== cur.addr ||
                        bus_byteenable !== cur.be || (cur.wr && bus_writedata !== cur.data)) begin
                        n_fail++;
                        $display("FAIL %s.bus_req: got w=%b r=%b a=%h d=%h be=%b required w=%b r=%b a=%h d=%h be=%b",
                                 name, bus_write, bus_read, bus_address, bus_writedata, bus_byteenable,
                                 cur.wr, !cur.wr, cur.addr, cur.data, cur.be);
                    end
                end
            end else if (check_state == 2'b11) begin
                done = 1'b1;
                exp_rd = rd_q.pop_front();
                got_rd = cpu_data_readdata;
                n_cmp++;
                if (got_rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL %s.readdata: got %h required %h", name, got_rd, exp_rd);
                end
                n_cmp++;
                if (bus_read !== 1'b0 || bus_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s.done_strobe: r=%b w=%b required 0 0", name, bus_read, bus_write);
                end
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s.complete: DONE not reached within 200 cycles", name);
        end
        n_cmp++;
        if (stall != exp_stall) begin
            n_fail++;
            $display("FAIL %s.stall: got %0d required %0d", name, stall, exp_stall);
        end
        n_cmp++;
        if (strobe_cyc != exp_strobe) begin
            n_fail++;
            $display("FAIL %s.strobe_len: got %0d required %0d", name, strobe_cyc, exp_strobe);
        end
        n_cmp++;
        if (bus_error !== model_err) begin
            n_fail++;
            $display("FAIL %s.bus_error: got %b required %b", name, bus_error, model_err);
        end
    endtask

    task automatic cpu_idle();
        @(negedge clk);
        cpu_data_read   = 1'b0;
        cpu_data_write  = 1'b0;
        bus_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (check_state !== 2'b00 || bus_read !== 1'b0 || bus_write !== 1'b0 ||
            bus_address !== 32'h0 || bus_writedata !== 32'h0 || bus_byteenable !== 4'h0 ||
            cpu_data_readdata !== 32'h0 || bus_error !== 1'b0 || cpu_clk_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset.outputs: st=%b r=%b w=%b a=%h d=%h be=%b rd=%h err=%b en=%b required all zero, en=1",
                     check_state, bus_read, bus_write, bus_address, bus_writedata, bus_byteenable,
                     cpu_data_readdata, bus_error, cpu_clk_enable);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        cpu_access(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, 1'b0, 2, 1, "zw_read");
    endtask

    task automatic test_wait_write();
        cpu_access(1'b0, 1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0011, 32'h5555_AAAA, 3, 1'b0, 5, 4, "ws_write");
        cpu_idle();
    endtask

    task automatic test_read_write_both();
        cpu_access(1'b1, 1'b1, 32'h0000_300B, 32'hA5A5_0F0F, 4'b1100, 32'h7777_7777, 1, 1'b0, 3, 2, "rw_both");
        cpu_idle();
    endtask

    task automatic test_back_to_back();
        int unsigned p0;
        p0 = pulses;
        cpu_access(1'b1, 1'b0, 32'h0000_4001, 32'h0, 4'b1111, 32'h0BAD_C0DE, 0, 1'b0, 2, 1, "b2b_read");
        cpu_access(1'b0, 1'b1, 32'h0000_4007, 32'h8765_4321, 4'b1000, 32'h0, 2, 1'b0, 4, 3, "b2b_write");
        cpu_idle();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (pulses - p0 != 2 || check_state !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b.pulses: got %0d trains state=%b required 2 trains state=00",
                     pulses - p0, check_state);
        end
    endtask

    task automatic test_timeout();
        cpu_access(1'b1, 1'b0, 32'h0000_5004, 32'h0, 4'b1111, 32'h1111_2222, 1000, 1'b1, 5, 4, "timeout");
        cpu_idle();
        #1;
        n_cmp++;
        if (check_state !== 2'b00 || bus_error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout.after: state=%b err=%b required 00 1", check_state, bus_error);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned p0;
        @(negedge clk);
        cpu_data_read    = 1'b1;
        cpu_data_address = 32'h0000_6008;
        bus_waitrequest  = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (check_state !== 2'b01 || bus_read !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid.pre: state=%b r=%b required 01 1", check_state, bus_read);
        end
        #2;
        reset         = 1'b0;
        cpu_data_read = 1'b0;
        #1;
        n_cmp++;
        if (bus_read !== 1'b0 || bus_write !== 1'b0 || check_state !== 2'b00 ||
            cpu_clk_enable !== 1'b1 || bus_error !== 1'b0 || bus_address !== 32'h0 ||
            cpu_data_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid.async: r=%b w=%b st=%b en=%b err=%b a=%h rd=%h required 0 0 00 1 0 0 0",
                     bus_read, bus_write, check_state, cpu_clk_enable, bus_error, bus_address,
                     cpu_data_readdata);
        end
        model_err   = 1'b0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        p0 = pulses;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (check_state !== 2'b00 || pulses != p0 || bus_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid.no_retry: state=%b new_trains=%0d r=%b required 00 0 0",
                     check_state, pulses - p0, bus_read);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        cpu_idle();
        test_wait_write();
        test_read_write_both();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
